vector_fetch_unit: RTL and testbench
====================================

// Module: vector_fetch_unit
// PURPOSE
//  Produces the PC load stream consumed by the program counter (PCL_in/PCH_in/load side).
//  Arbitrates reset, NMI and IRQ, reads the 2-byte vector over a req/ack memory port,
//  and then issues a one-cycle pc_load with the assembled target address.
//  Sits between the interrupt pins, the memory bus arbiter and the program counter.
// PARAMETERS
//  VEC_NMI  16'hFFFA  address of the NMI vector low byte
//  VEC_RST  16'hFFFC  address of the reset vector low byte
//  VEC_IRQ  16'hFFFE  address of the IRQ/BRK vector low byte
// PORTS
//  clk         in   1   system clock; all logic is rising-edge
//  reset       in   1   synchronous, active-high
//  rst_req     in   1   soft reset request; level, sampled every cycle
//  nmi_n       in   1   NMI, active-low, falling-edge sensitive
//  irq_n       in   1   IRQ, active-low, level sensitive
//  i_flag      in   1   IRQ mask from the status register (1 = masked)
//  fetch_grant in   1   core is at an instruction boundary; NMI/IRQ may be serviced
//  mem_req     out  1   vector read request
//  mem_addr    out  16  vector read address
//  mem_data    in   8   read data; valid when mem_ack = 1
//  mem_ack     in   1   read complete; mem_data is captured in this cycle
//  PCL_out     out  8   target PC low byte to the program counter
//  PCH_out     out  8   target PC high byte to the program counter
//  pc_load     out  1   one-cycle load strobe to the program counter
//  vec_sel     out  2   source of the last load: 0=IRQ 1=NMI 2=RST 3=BRK
//  busy        out  1   vector fetch in progress
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rst_pend=1; nmi_prev=1; nmi_pend=0.
//  NMI detect: nmi_prev<=nmi_n; (nmi_prev & ~nmi_n) sets nmi_pend.
//    nmi_pend is cleared on entry to REQ_LO for NMI. An edge that arrives during any fetch stays latched.
//  rst_req=1 sets rst_pend.
//  IDLE priority, evaluated in a single cycle:
//    rst_pend (no grant required) > nmi_pend & fetch_grant > ~irq_n & ~i_flag & fetch_grant.
//    IRQ is not latched. If its conditions drop before service, it is lost.
//  States: IDLE -> REQ_LO -> REQ_HI -> LOAD -> IDLE.
//    REQ_LO: mem_req=1, mem_addr=VEC. Hold until mem_ack; then PCL_r<=mem_data and go to REQ_HI.
//    REQ_HI: mem_req=1, mem_addr=VEC+1. Hold until mem_ack; then PCH_r<=mem_data and go to LOAD.
//    LOAD: pc_load=1 for exactly one cycle; mem_req=0.
//      PCL_out/PCH_out/vec_sel update here and hold until the next LOAD.
//  Clearing rst_pend: on entry to REQ_LO for a reset service.
//  busy=1 in REQ_LO, REQ_HI and LOAD.
//  Latency: with mem_ack in each request's first cycle, pc_load is 3 cycles after leaving IDLE.
//  mem_req stays high across the REQ_LO->REQ_HI change. The address switches on the cycle after the ack.
//  Address wrap: VEC+1 is computed mod 2^16 (FFFF+1 = 0000).
//  rst_req during REQ_LO/REQ_HI:
//    abort the fetch; the next cycle is REQ_LO at VEC_RST with vec_sel pending=2.
//    No pc_load is issued for the aborted fetch. An aborted NMI stays cleared.
//  rst_req during LOAD: the load completes, then the reset fetch starts from IDLE.
//  Hard reset mid-fetch: immediate return to reset values; the reset vector is fetched afterwards.
//  NMI edge and IRQ in the same IDLE cycle: NMI is serviced; IRQ is re-evaluated in the next IDLE.
//  A mem_ack outside REQ_LO/REQ_HI is ignored.
// CONFIGURATION
//  BRK_VECTOR_EN defined:
//    adds input brk_req (1 bit), a level held until pc_load.
//    Priority is below NMI and above IRQ. It is serviced only with fetch_grant.
//    It ignores i_flag, uses VEC_IRQ, and gives vec_sel=3.
//  BRK_VECTOR_EN undefined: no brk_req port; vec_sel never equals 3.
// TESTING
//  Reset 2 cycles, mem returns FC=34 FD=12, ack in the same cycle
//    -> addr FFFC then FFFD; pc_load 1 cycle; PCH:PCL=1234, vec_sel=2.
//  nmi_n 1->0 while busy on IRQ fetch, fetch_grant=1
//    -> IRQ load completes (vec_sel=0), then FFFA/FFFB are fetched with vec_sel=1.
//  irq_n=0 with i_flag=1
//    -> no mem_req; after i_flag=0 and fetch_grant=1 -> fetch at FFFE.
//  mem_ack delayed 3 cycles on each byte
//    -> mem_req and mem_addr held stable; pc_load follows exactly 1 cycle after the second ack.
//  rst_req pulse during an NMI REQ_HI
//    -> no pc_load for the NMI; next mem_addr=FFFC; final vec_sel=2.
//  BRK_VECTOR_EN: brk_req=1, i_flag=1, fetch_grant=1
//    -> fetch at FFFE; vec_sel=3.

Source files
------------

// File: rtl/vector_fetch_unit_if.sv
// Vector read port between the vector fetch unit (master) and the memory
// bus arbiter (slave). The request is held until the slave returns mem_ack
// together with valid mem_data.
interface vector_fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_data,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_data,
        output mem_ack
    );
endinterface

// File: rtl/vector_fetch_unit.sv
// Vector fetch unit: arbitrates reset / NMI / IRQ (and optionally BRK),
// reads the two-byte vector over a req/ack port and issues a one-cycle
// pc_load with the assembled target address to the program counter.
//
// Optional feature macro: BRK_VECTOR_EN
//   defined   -> adds input brk_req; serviced below NMI and above IRQ with
//                fetch_grant, ignores i_flag, uses VEC_IRQ, vec_sel = 3.
//   undefined -> no brk_req port; vec_sel never reports 3.
module vector_fetch_unit #(
    parameter logic [15:0] VEC_NMI = 16'hFFFA,
    parameter logic [15:0] VEC_RST = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rst_req,
    input  logic                       nmi_n,
    input  logic                       irq_n,
    input  logic                       i_flag,
    input  logic                       fetch_grant,
`ifdef BRK_VECTOR_EN
    input  logic                       brk_req,
`endif
    vector_fetch_unit_if.master        mem,
    output logic [7:0]                 PCL_out,
    output logic [7:0]                 PCH_out,
    output logic                       pc_load,
    output logic [1:0]                 vec_sel,
    output logic                       busy
);

    // Source encodings double as the vec_sel values reported on load.
    localparam logic [1:0] SRC_IRQ = 2'd0;
    localparam logic [1:0] SRC_NMI = 2'd1;
    localparam logic [1:0] SRC_RST = 2'd2;
    localparam logic [1:0] SRC_BRK = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_LO = 2'd1,
        ST_REQ_HI = 2'd2,
        ST_LOAD   = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  src_r, src_s;
    logic        rst_pend_r;
    logic        nmi_prev_r;
    logic        nmi_pend_r;
    logic [7:0]  pcl_r;

    logic        nmi_edge_s;
    logic        in_req_s;
    logic        rst_entry_s;
    logic        nmi_entry_s;
    logic        cap_lo_s;
    logic        cap_hi_s;
    logic        mem_req_s;
    logic [15:0] mem_addr_s;
    logic        pc_load_s;
    logic        busy_s;

    logic        mem_req_r;
    logic [15:0] mem_addr_r;
    logic        pc_load_r;
    logic        busy_r;
    logic [7:0]  pcl_out_r;
    logic [7:0]  pch_out_r;
    logic [1:0]  vec_sel_r;

    // Low-byte vector address for a given service source; BRK shares IRQ.
    function automatic logic [15:0] vec_base(input logic [1:0] src);
        case (src)
            SRC_IRQ: vec_base = VEC_IRQ;
            SRC_NMI: vec_base = VEC_NMI;
            SRC_RST: vec_base = VEC_RST;
            SRC_BRK: vec_base = VEC_IRQ;
            default: vec_base = VEC_IRQ;
        endcase
    endfunction

    assign nmi_edge_s = nmi_prev_r & ~nmi_n;
    assign in_req_s   = (state_r == ST_REQ_LO) || (state_r == ST_REQ_HI);

    // Arbitration, fetch sequencing and next-cycle output values.
    always_comb begin
        state_s     = state_r;
        src_s       = src_r;
        rst_entry_s = 1'b0;
        nmi_entry_s = 1'b0;
        cap_lo_s    = 1'b0;
        cap_hi_s    = 1'b0;
        mem_req_s   = 1'b0;
        mem_addr_s  = 16'd0;
        pc_load_s   = 1'b0;
        busy_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // A same-cycle NMI edge counts so it beats a simultaneous IRQ.
                if (rst_pend_r) begin
                    state_s     = ST_REQ_LO;
                    src_s       = SRC_RST;
                    rst_entry_s = 1'b1;
                end else if ((nmi_pend_r | nmi_edge_s) & fetch_grant) begin
                    state_s     = ST_REQ_LO;
                    src_s       = SRC_NMI;
                    nmi_entry_s = 1'b1;
`ifdef BRK_VECTOR_EN
                end else if (brk_req & fetch_grant) begin
                    state_s     = ST_REQ_LO;
                    src_s       = SRC_BRK;
`endif
                end else if (~irq_n & ~i_flag & fetch_grant) begin
                    state_s     = ST_REQ_LO;
                    src_s       = SRC_IRQ;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_REQ_LO: begin
                // A soft reset request aborts and restarts at the reset vector.
                if (rst_req) begin
                    state_s     = ST_REQ_LO;
                    src_s       = SRC_RST;
                    rst_entry_s = 1'b1;
                end else if (mem.mem_ack) begin
                    state_s     = ST_REQ_HI;
                    cap_lo_s    = 1'b1;
                end else begin
                    state_s     = ST_REQ_LO;
                end
            end
            ST_REQ_HI: begin
                if (rst_req) begin
                    state_s     = ST_REQ_LO;
                    src_s       = SRC_RST;
                    rst_entry_s = 1'b1;
                end else if (mem.mem_ack) begin
                    state_s     = ST_LOAD;
                    cap_hi_s    = 1'b1;
                end else begin
                    state_s     = ST_REQ_HI;
                end
            end
            ST_LOAD: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        case (state_s)
            ST_REQ_LO: begin
                mem_req_s  = 1'b1;
                mem_addr_s = vec_base(src_s);
                busy_s     = 1'b1;
            end
            ST_REQ_HI: begin
                // 16-bit add wraps FFFF+1 to 0000.
                mem_req_s  = 1'b1;
                mem_addr_s = vec_base(src_s) + 16'd1;
                busy_s     = 1'b1;
            end
            ST_LOAD: begin
                pc_load_s  = 1'b1;
                busy_s     = 1'b1;
            end
            default: begin
                mem_req_s  = 1'b0;
            end
        endcase
    end

    // State, pending-request flags and the captured low vector byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            src_r      <= SRC_IRQ;
            rst_pend_r <= 1'b1;
            nmi_prev_r <= 1'b1;
            nmi_pend_r <= 1'b0;
            pcl_r      <= 8'd0;
        end else begin
            state_r    <= state_s;
            src_r      <= src_s;
            nmi_prev_r <= nmi_n;
            // An edge seen in the cycle its own service starts is consumed;
            // any other edge stays latched until serviced.
            nmi_pend_r <= (nmi_pend_r | nmi_edge_s) & ~nmi_entry_s;
            // During a fetch rst_req acts directly as an abort instead.
            rst_pend_r <= (rst_pend_r & ~rst_entry_s) | (rst_req & ~in_req_s);
            if (cap_lo_s) begin
                pcl_r <= mem.mem_data;
            end else begin
                pcl_r <= pcl_r;
            end
        end
    end

    // Registered bus and program-counter outputs; target held until next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_r  <= 1'b0;
            mem_addr_r <= 16'd0;
            pc_load_r  <= 1'b0;
            busy_r     <= 1'b0;
            pcl_out_r  <= 8'd0;
            pch_out_r  <= 8'd0;
            vec_sel_r  <= 2'd0;
        end else begin
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
            pc_load_r  <= pc_load_s;
            busy_r     <= busy_s;
            if (cap_hi_s) begin
                pcl_out_r <= pcl_r;
                pch_out_r <= mem.mem_data;
                vec_sel_r <= src_r;
            end else begin
                pcl_out_r <= pcl_out_r;
                pch_out_r <= pch_out_r;
                vec_sel_r <= vec_sel_r;
            end
        end
    end

    assign mem.mem_req  = mem_req_r;
    assign mem.mem_addr = mem_addr_r;
    assign pc_load      = pc_load_r;
    assign busy         = busy_r;
    assign PCL_out      = pcl_out_r;
    assign PCH_out      = pch_out_r;
    assign vec_sel      = vec_sel_r;

endmodule

// File: tb/tb_vector_fetch_unit.sv
// Self-checking bench for vector_fetch_unit: a per-cycle reference model,
// a table of single-service scenarios, hand sequences for the multi-cycle
// corner cases and a randomized phase with random acks and stray acks.
module tb_vector_fetch_unit;

    logic       clk;
    logic       reset, rst_req, nmi_n, irq_n, i_flag, fetch_grant;
`ifdef BRK_VECTOR_EN
    logic       brk_req;
`endif
    logic [7:0] PCL_out, PCH_out;
    logic       pc_load, busy;
    logic [1:0] vec_sel;

    vector_fetch_unit_if mem_bus ();

    vector_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .rst_req     (rst_req),
        .nmi_n       (nmi_n),
        .irq_n       (irq_n),
        .i_flag      (i_flag),
        .fetch_grant (fetch_grant),
`ifdef BRK_VECTOR_EN
        .brk_req     (brk_req),
`endif
        .mem         (mem_bus),
        .PCL_out     (PCL_out),
        .PCH_out     (PCH_out),
        .pc_load     (pc_load),
        .vec_sel     (vec_sel),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Vector table contents seen by the memory responder and the model.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'hFFFA: mem_byte = 8'h78;
            16'hFFFB: mem_byte = 8'h56;
            16'hFFFC: mem_byte = 8'h34;
            16'hFFFD: mem_byte = 8'h12;
            16'hFFFE: mem_byte = 8'hBC;
            16'hFFFF: mem_byte = 8'h9A;
            default:  mem_byte = a[7:0] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [15:0] vec_addr(input logic [1:0] src);
        case (src)
            2'd1:    vec_addr = 16'hFFFA;
            2'd2:    vec_addr = 16'hFFFC;
            default: vec_addr = 16'hFFFE;
        endcase
    endfunction

    // Memory responder: fixed ack delay per request or random acks.
    int          ack_delay = 0;
    bit          rand_ack  = 0;
    bit          stray_en  = 0;
    initial begin
        int          cnt;
        bit          req_seen;
        logic [15:0] last_addr;
        bit          give;
        cnt = 0; req_seen = 0; last_addr = 16'd0;
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_data = 8'd0;
        forever begin
            @(negedge clk);
            if (mem_bus.mem_req) begin
                if (!req_seen || mem_bus.mem_addr != last_addr || mem_bus.mem_ack) cnt = 0;
                else cnt++;
                req_seen  = 1;
                last_addr = mem_bus.mem_addr;
                give = rand_ack ? ($urandom_range(0, 2) == 0) : (cnt >= ack_delay);
                mem_bus.mem_ack  = give;
                mem_bus.mem_data = give ? mem_byte(mem_bus.mem_addr) : 8'($urandom);
            end else begin
                req_seen = 0;
                mem_bus.mem_ack  = stray_en ? ($urandom_range(0, 3) == 0) : 1'b0;
                mem_bus.mem_data = 8'($urandom);
            end
        end
    end

    // Reference model: pending flags plus "which fetch, which byte" state.
    bit         chk_en = 0;
    bit         m_rst_pend, m_nmi_pend, m_nmi_prev;
    bit         m_fetch, m_hi, m_load;
    logic [1:0] m_src, m_vsel;
    logic [7:0] m_lo, m_pcl, m_pch;

    task automatic model_step();
        bit edge_seen;
        if (reset) begin
            m_rst_pend = 1; m_nmi_pend = 0; m_nmi_prev = 1;
            m_fetch = 0; m_hi = 0; m_load = 0; m_src = 2'd0;
            m_vsel = 2'd0; m_lo = 8'd0; m_pcl = 8'd0; m_pch = 8'd0;
            chk_en = 1;
            return;
        end
        edge_seen = m_nmi_prev && !nmi_n;
        if (m_fetch) begin
            m_nmi_pend = m_nmi_pend | edge_seen;
            if (rst_req) begin
                m_src = 2'd2; m_hi = 0; m_rst_pend = 0;
            end else if (mem_bus.mem_ack) begin
                if (!m_hi) begin
                    m_lo = mem_byte(vec_addr(m_src));
                    m_hi = 1;
                end else begin
                    m_fetch = 0; m_load = 1; m_pcl = m_lo;
                    m_pch = mem_byte(vec_addr(m_src) + 16'd1);
                    m_vsel = m_src;
                end
            end
        end else begin
            if (m_load) begin
                m_load = 0;
            end else if (m_rst_pend) begin
                m_fetch = 1; m_hi = 0; m_src = 2'd2; m_rst_pend = 0;
            end else if ((m_nmi_pend || edge_seen) && fetch_grant) begin
                m_fetch = 1; m_hi = 0; m_src = 2'd1; m_nmi_pend = 0; edge_seen = 0;
`ifdef BRK_VECTOR_EN
            end else if (brk_req && fetch_grant) begin
                m_fetch = 1; m_hi = 0; m_src = 2'd3;
`endif
            end else if (!irq_n && !i_flag && fetch_grant) begin
                m_fetch = 1; m_hi = 0; m_src = 2'd0;
            end
            m_rst_pend = m_rst_pend | rst_req;
            m_nmi_pend = m_nmi_pend | edge_seen;
        end
        m_nmi_prev = nmi_n;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en)
            check("cycle",
                  64'({mem_bus.mem_req, mem_bus.mem_addr, pc_load, busy, PCL_out, PCH_out, vec_sel}),
                  64'({m_fetch, (m_fetch ? vec_addr(m_src) + {15'd0, m_hi} : 16'd0),
                       m_load, (m_fetch | m_load), m_pcl, m_pch, m_vsel}));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_for(input bit want_load, input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            if (want_load ? pc_load : mem_bus.mem_req) begin
                ok = 1;
                break;
            end
            tick(1);
        end
        check({name, "_wait"}, 64'(ok), 64'd1);
    endtask

    typedef struct {
        logic        srst, nmi, irq, iflag, grant, brk;
        int          delay;
        logic        fetch;
        logic [15:0] addr0;
        logic [15:0] pc;
        logic [1:0]  vsel;
    } row_t;
    row_t rows[$];

    task automatic add_row(input logic srst, nmi, irq, iflag, grant, brk, input int delay,
                           input logic fetch, input logic [15:0] addr0, pc, input logic [1:0] vsel);
        row_t r;
        r.srst = srst; r.nmi = nmi; r.irq = irq; r.iflag = iflag; r.grant = grant; r.brk = brk;
        r.delay = delay; r.fetch = fetch; r.addr0 = addr0; r.pc = pc; r.vsel = vsel;
        rows.push_back(r);
    endtask

    initial begin
        row_t        v;
        bit          seen_req, got_load, early;
        logic [15:0] addr0;
        int          acks, loads;

        reset = 1; rst_req = 0; nmi_n = 1; irq_n = 1; i_flag = 1; fetch_grant = 0;
`ifdef BRK_VECTOR_EN
        brk_req = 0;
`endif
        //          srst nmi irq ifl grant brk dly fetch addr0     pc        vsel
        add_row(0,  0,  1,  0,  1,   0,  0,  1,  16'hFFFE, 16'h9ABC, 2'd0);
        add_row(0,  1,  0,  1,  1,   0,  1,  1,  16'hFFFA, 16'h5678, 2'd1);
        add_row(1,  0,  0,  1,  0,   0,  0,  1,  16'hFFFC, 16'h1234, 2'd2);
        add_row(0,  0,  1,  1,  1,   0,  0,  0,  16'h0000, 16'h0000, 2'd0);
        add_row(0,  0,  1,  0,  0,   0,  0,  0,  16'h0000, 16'h0000, 2'd0);
        add_row(0,  1,  1,  0,  1,   0,  2,  1,  16'hFFFA, 16'h5678, 2'd1);
        add_row(1,  0,  1,  0,  1,   0,  1,  1,  16'hFFFC, 16'h1234, 2'd2);
`ifdef BRK_VECTOR_EN
        add_row(0,  0,  0,  1,  1,   1,  0,  1,  16'hFFFE, 16'h9ABC, 2'd3);
        add_row(0,  1,  0,  1,  1,   1,  0,  1,  16'hFFFA, 16'h5678, 2'd1);
        add_row(0,  0,  1,  0,  1,   1,  1,  1,  16'hFFFE, 16'h9ABC, 2'd3);
        add_row(0,  0,  0,  1,  0,   1,  0,  0,  16'h0000, 16'h0000, 2'd0);
`endif

        // Reset state, then the automatic reset-vector fetch.
        tick(2);
        check("reset_state",
              64'({mem_bus.mem_req, mem_bus.mem_addr, pc_load, busy, PCL_out, PCH_out, vec_sel}), 64'd0);
        reset = 0;
        wait_for(0, "rst_req_lo");
        check("rst_lo", 64'({mem_bus.mem_req, mem_bus.mem_addr}), 64'({1'b1, 16'hFFFC}));
        tick(1);
        check("rst_hi", 64'({mem_bus.mem_req, mem_bus.mem_addr}), 64'({1'b1, 16'hFFFD}));
        tick(1);
        check("rst_load", 64'({pc_load, PCH_out, PCL_out, vec_sel}), 64'({1'b1, 16'h1234, 2'd2}));
        tick(1);
        check("rst_load_one_cycle", 64'({pc_load, busy}), 64'd0);
        tick(2);

        // Table of single-service scenarios.
        for (int r = 0; r < rows.size(); r++) begin
            v = rows[r];
            ack_delay = v.delay;
            rst_req = v.srst; fetch_grant = 0;
            tick(1);
            rst_req = 0; irq_n = !v.irq; i_flag = v.iflag; fetch_grant = v.grant; nmi_n = !v.nmi;
`ifdef BRK_VECTOR_EN
            brk_req = v.brk;
`endif
            tick(1);
            nmi_n = 1;
            seen_req = 0; got_load = 0; addr0 = 16'd0;
            for (int c = 0; c < 20 && !got_load; c++) begin
                if (mem_bus.mem_req && !seen_req) begin
                    seen_req = 1;
                    addr0 = mem_bus.mem_addr;
                end
                if (pc_load) got_load = 1;
                else tick(1);
            end
            if (v.fetch)
                check($sformatf("row%0d_load", r), 64'({got_load, addr0, PCH_out, PCL_out, vec_sel}),
                      64'({1'b1, v.addr0, v.pc, v.vsel}));
            else
                check($sformatf("row%0d_idle", r), 64'({seen_req, got_load}), 64'd0);
            irq_n = 1; i_flag = 1; fetch_grant = 0;
`ifdef BRK_VECTOR_EN
            brk_req = 0;
`endif
            tick(3);
        end

        // NMI edge while an IRQ fetch is in flight.
        ack_delay = 1;
        irq_n = 0; i_flag = 0; fetch_grant = 1;
        wait_for(0, "irq_req");
        check("irq_addr", 64'(mem_bus.mem_addr), 64'(16'hFFFE));
        nmi_n = 0;
        tick(1);
        nmi_n = 1;
        wait_for(1, "irq_load");
        check("irq_then_nmi_first", 64'({PCH_out, PCL_out, vec_sel}), 64'({16'h9ABC, 2'd0}));
        irq_n = 1;
        tick(1);
        wait_for(0, "nmi_req");
        check("nmi_addr", 64'(mem_bus.mem_addr), 64'(16'hFFFA));
        wait_for(1, "nmi_load");
        check("nmi_after_irq", 64'({PCH_out, PCL_out, vec_sel}), 64'({16'h5678, 2'd1}));
        fetch_grant = 0; i_flag = 1;
        tick(3);

        // Acks delayed by three cycles on each byte.
        ack_delay = 3;
        rst_req = 1;
        tick(1);
        rst_req = 0;
        acks = 0; early = 0;
        for (int c = 0; c < 40 && acks < 2; c++) begin
            tick(1);
            if (pc_load) early = 1;
            if (mem_bus.mem_req && mem_bus.mem_ack) acks++;
        end
        tick(1);
        check("delay_load", 64'({early, acks[1:0], pc_load, PCH_out, PCL_out}), 64'({1'b0, 2'd2, 1'b1, 16'h1234}));
        tick(3);

        // rst_req pulse during the high byte of an NMI fetch.
        ack_delay = 2;
        nmi_n = 0; fetch_grant = 1;
        tick(1);
        nmi_n = 1;
        seen_req = 0;
        for (int c = 0; c < 20 && !seen_req; c++) begin
            if (mem_bus.mem_req && mem_bus.mem_addr == 16'hFFFB) seen_req = 1;
            else tick(1);
        end
        check("nmi_hi_reached", 64'(seen_req), 64'd1);
        fetch_grant = 0; rst_req = 1;
        tick(1);
        rst_req = 0;
        check("abort_addr", 64'({mem_bus.mem_req, mem_bus.mem_addr}), 64'({1'b1, 16'hFFFC}));
        loads = 0;
        for (int c = 0; c < 20; c++) begin
            if (pc_load) loads++;
            tick(1);
        end
        check("abort_single_load", 64'({loads[3:0], PCH_out, PCL_out, vec_sel}), 64'({4'd1, 16'h1234, 2'd2}));

        // IRQ masked by i_flag, then unmasked.
        ack_delay = 0;
        irq_n = 0; i_flag = 1; fetch_grant = 1;
        seen_req = 0;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            if (mem_bus.mem_req) seen_req = 1;
        end
        check("irq_masked", 64'(seen_req), 64'd0);
        i_flag = 0;
        wait_for(0, "unmask_req");
        check("unmask_addr", 64'(mem_bus.mem_addr), 64'(16'hFFFE));
        wait_for(1, "unmask_load");
        irq_n = 1; i_flag = 1; fetch_grant = 0;
        tick(3);

        // Randomized phase against the model, with stray acks and hard resets.
        rand_ack = 1; stray_en = 1;
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 999) == 0);
            rst_req     = ($urandom_range(0, 59) == 0);
            nmi_n       = ($urandom_range(0, 9) != 0);
            irq_n       = ($urandom_range(0, 1) == 1);
            i_flag      = ($urandom_range(0, 2) == 0);
            fetch_grant = ($urandom_range(0, 1) == 1);
`ifdef BRK_VECTOR_EN
            brk_req     = ($urandom_range(0, 7) == 0);
`endif
            tick(1);
        end
        reset = 0; rst_req = 0; nmi_n = 1; irq_n = 1; i_flag = 1; fetch_grant = 0;
`ifdef BRK_VECTOR_EN
        brk_req = 0;
`endif
        rand_ack = 0; stray_en = 0;
        tick(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
